// File: rtl/arinc429_tx_fifo.sv
// ARINC 429 transmitter: word FIFO feeding a bipolar RZ serialiser with
// selectable bus speed, programmable inter-word gap and odd/pass-through parity.
module arinc429_tx_fifo #(
    parameter int unsigned FCLK     = 50000000,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned GAP_BITS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   nvel,
    input  logic                         par_mode,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_label,
    input  logic [22:0]                  wr_data,
    input  logic                         wr_par,
    input  logic                         ovf_clr,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf,
    output logic                         busy,
    output logic                         word_done,
    output logic                         txd1,
    output logic                         txd0,
    output logic                         slp
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned LW        = $clog2(DEPTH + 1);
    localparam int unsigned HB_HALVES = (2 * GAP_BITS > 64) ? 2 * GAP_BITS : 64;
    localparam int unsigned HBW       = $clog2(HB_HALVES);

    localparam logic [10:0] NH3_M1 = 11'(FCLK / 2000000 - 1);
    localparam logic [10:0] NH2_M1 = 11'(FCLK / 200000 - 1);
    localparam logic [10:0] NH1_M1 = 11'(FCLK / 100000 - 1);
    localparam logic [10:0] NH0_M1 = 11'(FCLK / 25000 - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t            state, state_n;
    logic [32:0]       mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [LW-1:0]     cnt;
    logic [32:0]       head;
    logic [31:0]       line_word;
    logic [31:0]       word;
    logic [10:0]       nh_m1, nh_sel;
    logic [10:0]       hcnt;
    logic [HBW-1:0]    hb;
    logic              pop, push, avail, half_end, send_last, gap_last, cur_bit;

    // FIFO entry layout: {par_mode, wr_par, wr_data, wr_label}
    assign head      = mem[rd_ptr];
    assign pop       = (state == LOAD);
    assign full      = (cnt == LW'(DEPTH));
    assign push      = wr_en && (!full || pop);
    assign avail     = (cnt != '0) || wr_en;
    assign level     = cnt;
    assign busy      = (state != IDLE);

    // hb counts half-bits: hb[0] selects the null half, hb[5:1] is the bit index
    assign half_end  = (hcnt == nh_m1);
    assign send_last = (state == SEND) && half_end && (hb == HBW'(63));
    assign gap_last  = (state == GAP) && half_end && (hb == HBW'(2 * GAP_BITS - 1));
    assign word_done = send_last;
    assign cur_bit   = word[hb[5:1]];
    assign txd1      = (state == SEND) && !hb[0] && cur_bit;
    assign txd0      = (state == SEND) && !hb[0] && !cur_bit;

    always_comb begin
        line_word = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            line_word[i] = head[7 - i];
        end
        line_word[30:8] = head[30:8];
        line_word[31]   = head[32] ? head[31] : ~^head[30:0];
    end

    always_comb begin
        nh_sel = NH0_M1;
        unique case (nvel)
            2'd3:    nh_sel = NH3_M1;
            2'd2:    nh_sel = NH2_M1;
            2'd1:    nh_sel = NH1_M1;
            default: nh_sel = NH0_M1;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (avail) state_n = LOAD;
            LOAD:    state_n = SEND;
            SEND:    if (send_last) state_n = GAP;
            GAP:     if (gap_last) state_n = avail ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {par_mode, wr_par, wr_data, wr_label};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            word   <= '0;
            nh_m1  <= '0;
            slp    <= 1'b0;
            hcnt   <= '0;
            hb     <= '0;
        end else begin
            state <= state_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;

            // a dropped write in the same cycle as ovf_clr keeps ovf set
            if (ovf_clr)         ovf <= 1'b0;
            if (wr_en && !push)  ovf <= 1'b1;

            if (state == LOAD) begin
                word  <= line_word;
                nh_m1 <= nh_sel;
                slp   <= (nvel == 2'd0);
                hcnt  <= '0;
                hb    <= '0;
            end else if (state == SEND || state == GAP) begin
                if (half_end) begin
                    hcnt <= '0;
                    hb   <= send_last ? '0 : hb + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_arinc429_tx_fifo.sv
// Directed/randomised bench for arinc429_tx_fifo: decodes the RZ line into
// pulses and compares them with words built from the transmit rules.
module tb_arinc429_tx_fifo;

    localparam int unsigned FCLK     = 8000000;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned GAP_BITS = 6;
    localparam int          LW       = $clog2(DEPTH + 1);

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic [1:0]    nvel     = 2'd2;
    logic          par_mode = 1'b0;
    logic          wr_en    = 1'b0;
    logic [7:0]    wr_label = '0;
    logic [22:0]   wr_data  = '0;
    logic          wr_par   = 1'b0;
    logic          ovf_clr  = 1'b0;
    logic          full, ovf, busy, word_done, txd1, txd0, slp;
    logic [LW-1:0] level;

    arinc429_tx_fifo #(
        .FCLK     (FCLK),
        .DEPTH    (DEPTH),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .nvel      (nvel),
        .par_mode  (par_mode),
        .wr_en     (wr_en),
        .wr_label  (wr_label),
        .wr_data   (wr_data),
        .wr_par    (wr_par),
        .ovf_clr   (ovf_clr),
        .full      (full),
        .level     (level),
        .ovf       (ovf),
        .busy      (busy),
        .word_done (word_done),
        .txd1      (txd1),
        .txd0      (txd0),
        .slp       (slp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int start; int len; bit val;} pulse_t;
    typedef struct {logic [31:0] bits; int nh;} exp_t;

    pulse_t pq[$];
    int     wd_q[$];
    exp_t   eq[$];
    bit     both_hi = 1'b0;
    bit     act = 1'b0;
    bit     cur_val = 1'b0;
    int     cur_start = 0;
    int     cur_len = 0;

    // Line monitor: every bit is one pulse on either txd1 or txd0
    always @(negedge clk) begin
        if (txd1 && txd0) both_hi = 1'b1;
        if (txd1 || txd0) begin
            if (!act) begin
                act = 1'b1; cur_start = cyc; cur_len = 1; cur_val = txd1;
            end else begin
                cur_len++;
            end
        end else if (act) begin
            act = 1'b0;
            pq.push_back('{cur_start, cur_len, cur_val});
        end
        if (word_done === 1'b1) wd_q.push_back(cyc);
    end

    int checks = 0;
    int errors = 0;
    int pidx   = 0;

    function automatic int nh_of(input logic [1:0] v);
        int rate;
        case (v)
            2'd3:    rate = 1000000;
            2'd2:    rate = 100000;
            2'd1:    rate = 50000;
            default: rate = 12500;
        endcase
        return int'(FCLK) / (2 * rate);
    endfunction

    function automatic logic [31:0] line_bits(input logic [7:0] l, input logic [22:0] d,
                                              input bit pm, input bit wp);
        logic [31:0] b;
        int ones;
        b = '0;
        for (int k = 0; k < 8; k++) b[k] = l[7 - k];
        for (int k = 0; k < 23; k++) b[8 + k] = d[k];
        ones = $countones(l) + $countones(d);
        b[31] = pm ? wp : ((ones % 2) == 0);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] l, input logic [22:0] d, input bit pm,
                            input bit wp, input int nh);
        exp_t e;
        e.bits = line_bits(l, d, pm, wp);
        e.nh   = nh;
        eq.push_back(e);
    endtask

    task automatic wr(input logic [7:0] l, input logic [22:0] d, input bit pm,
                      input bit wp, output int t);
        wr_en = 1'b1; wr_label = l; wr_data = d; par_mode = pm; wr_par = wp;
        t = cyc;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_wd(output int t);
        int n = 0;
        while (word_done !== 1'b1 && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk("word_done_seen", word_done, 1);
        t = cyc;
    endtask

    task automatic check_word(input int exp_start, output logic [31:0] got, output int st);
        exp_t e;
        bit   tim_ok;
        got = '0; st = -1; tim_ok = 1'b1;
        e = eq.pop_front();
        chk("pulses_avail", (pq.size() >= pidx + 32), 1);
        if (pq.size() >= pidx + 32) begin
            st = pq[pidx].start;
            for (int k = 0; k < 32; k++) begin
                got[k] = pq[pidx + k].val;
                if (pq[pidx + k].len != e.nh) tim_ok = 1'b0;
                if (k > 0 && pq[pidx + k].start - pq[pidx + k - 1].start != 2 * e.nh) tim_ok = 1'b0;
            end
            pidx += 32;
        end
        chk("word_bits", got, e.bits);
        chk("bit_timing", tim_ok, 1);
        if (exp_start >= 0) chk("word_start", st, exp_start);
    endtask

    initial begin
        int n, t, t2, s, st, base, w0, k;
        logic [31:0] got;
        logic [7:0]  l;
        logic [22:0] d;

        repeat (3) @(negedge clk);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word_done", word_done, 0);
        chk("rst_txd", {txd1, txd0}, 0);
        chk("rst_slp", slp, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single word at 100 kb/s, label 0x81 data 1
        nvel = 2'd2;
        push_exp(8'h81, 23'h1, 0, 0, nh_of(2));
        wr(8'h81, 23'h1, 0, 0, n);
        chk("level_n1", level, 1);
        chk("busy_load", busy, 1);
        chk("txd_n1", {txd1, txd0}, 0);
        @(negedge clk);
        chk("level_n2", level, 0);
        chk("txd_first_half", {txd1, txd0}, 2'b10);
        wait_wd(t);
        chk("wd_cycle", t, n + 2 + 64 * nh_of(2) - 1);
        @(negedge clk);
        chk("wd_one_cycle", word_done, 0);
        check_word(n + 2, got, st);
        repeat (2 * GAP_BITS * nh_of(2) - 1) @(negedge clk);
        chk("busy_gap_end", busy, 1);
        @(negedge clk);
        chk("busy_idle", busy, 0);

        // Three back-to-back words at 1 Mb/s
        nvel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            l = 8'($urandom); d = 23'($urandom);
            push_exp(l, d, 0, 0, nh_of(3));
            wr(l, d, 0, 0, t);
            if (i == 0) n = t;
        end
        chk("level_after3", level, 2);
        s = n + 2;
        for (int i = 0; i < 3; i++) begin
            wait_wd(t);
            chk("level_at_wd", level, 2 - i);
            chk("wd_vs_start", t, s + 64 * nh_of(3) - 1);
            @(negedge clk);
            check_word(s, got, st);
            s = s + 64 * nh_of(3) + 2 * GAP_BITS * nh_of(3) + 1;
        end
        repeat (2 * GAP_BITS * nh_of(3) + 2) @(negedge clk);
        chk("idle_after3", busy, 0);

        // Fill while sending, overflow, ovf_clr, write-with-pop while full
        l = 8'($urandom); d = 23'($urandom);
        push_exp(l, d, 0, 0, nh_of(3));
        wr(l, d, 0, 0, n);
        for (int i = 0; i < int'(DEPTH); i++) begin
            l = 8'($urandom); d = 23'($urandom);
            push_exp(l, d, 0, 0, nh_of(3));
            wr(l, d, 0, 0, t);
        end
        chk("full_set", full, 1);
        chk("level_full", level, DEPTH);
        chk("ovf_before", ovf, 0);
        l = 8'($urandom); d = 23'($urandom);
        wr(l, d, 0, 0, t);
        chk("ovf_set", ovf, 1);
        chk("level_after_drop", level, DEPTH);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);
        ovf_clr = 1'b1;
        wr(l, d ^ 23'h5a5a5, 0, 0, t);
        ovf_clr = 1'b0;
        chk("ovf_clr_and_set", ovf, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        wait_wd(t);
        repeat (2 * GAP_BITS * nh_of(3) + 1) @(negedge clk);
        chk("full_at_load", full, 1);
        l = 8'($urandom); d = 23'($urandom);
        push_exp(l, d, 0, 0, nh_of(3));
        wr(l, d, 0, 0, t2);
        chk("level_pop_write", level, DEPTH);
        chk("full_pop_write", full, 1);
        chk("ovf_pop_write", ovf, 0);
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            wait_wd(t);
            @(negedge clk);
        end
        k = eq.size();
        for (int i = 0; i < k; i++) check_word(-1, got, st);
        repeat (2 * GAP_BITS * nh_of(3) + 10) @(negedge clk);
        chk("no_dropped_word", pq.size(), pidx);
        chk("idle_after_fill", busy, 0);

        // Parity pass-through versus generated odd parity on even-weight data
        l = 8'($urandom); d = 23'($urandom);
        if ((($countones(l) + $countones(d)) % 2) != 0) d[0] = ~d[0];
        push_exp(l, d, 1, 0, nh_of(3));
        wr(l, d, 1, 0, t);
        push_exp(l, d, 0, 0, nh_of(3));
        wr(l, d, 0, 0, t);
        wait_wd(t);
        @(negedge clk);
        wait_wd(t);
        @(negedge clk);
        check_word(-1, got, st);
        chk("par_passthru", got[31], 0);
        check_word(-1, got, st);
        chk("par_odd_gen", got[31], 1);
        repeat (2 * GAP_BITS * nh_of(3) + 2) @(negedge clk);

        // Speed latched per word: nvel change mid-word applies to the next word
        nvel = 2'd0;
        l = 8'($urandom); d = 23'($urandom);
        push_exp(l, d, 0, 0, nh_of(0));
        wr(l, d, 0, 0, n);
        @(negedge clk);
        nvel = 2'd3;
        chk("slp_slow", slp, 1);
        l = 8'($urandom); d = 23'($urandom);
        push_exp(l, d, 0, 0, nh_of(3));
        wr(l, d, 0, 0, t);
        repeat (5000) @(negedge clk);
        chk("slp_mid_word", slp, 1);
        wait_wd(t);
        chk("slow_word_len", t - (n + 2), 64 * nh_of(0) - 1);
        @(negedge clk);
        repeat (2 * GAP_BITS * nh_of(0) - 1) @(negedge clk);
        chk("slp_in_gap", slp, 1);
        s = t + 2 * GAP_BITS * nh_of(0) + 2;
        wait_wd(t2);
        chk("slp_fast", slp, 0);
        @(negedge clk);
        check_word(n + 2, got, st);
        check_word(s, got, st);
        repeat (2 * GAP_BITS * nh_of(3) + 2) @(negedge clk);

        // Reset during bit 10 with words queued
        base = pq.size();
        for (int i = 0; i < 4; i++) begin
            l = 8'($urandom); d = 23'($urandom);
            wr(l, d, 0, 0, t);
        end
        for (int i = 0; i < 2000 && !(pq.size() >= base + 10 && (txd1 || txd0)); i++) begin
            @(negedge clk);
        end
        chk("reached_bit10", pq.size() - base, 10);
        w0 = wd_q.size();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_txd", {txd1, txd0}, 0);
        chk("rst_mid_level", level, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_full", full, 0);
        repeat (2500) @(negedge clk);
        chk("rst_no_wd", wd_q.size(), w0);
        chk("rst_line_quiet", pq.size(), base + 11);
        chk("never_both_lines", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arinc429_tx_fifo.md
# arinc429_tx_fifo

Parametrised ARINC 429 transmitter. A word FIFO accepts label/data writes and serialises them onto the bipolar RZ line pair (TXD1/TXD0) at one of four bus speeds. Between words it inserts a programmable inter-word gap. It generates odd parity or passes a supplied parity bit through. It sits between the host register interface and the ARINC 429 line driver, and drives the driver's slope-select pin.

## Interface
Parameters:
- FCLK, 50000000, system clock frequency in Hz.
- DEPTH, 8, FIFO depth in words; power of two, 2..64.
- GAP_BITS, 4, inter-word null time in bit periods; minimum 4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears FIFO, FSM, counters, flags.
- nvel  in  2  speed: 3 = 1 Mb/s, 2 = 100 kb/s, 1 = 50 kb/s, 0 = 12.5 kb/s.
- par_mode  in  1  0 = generate odd parity; 1 = transmit wr_par unchanged.
- wr_en  in  1  write strobe, one word per asserted cycle.
- wr_label  in  8  label (word bits 1-8).
- wr_data  in  23  SDI/data/SSM (word bits 9-31).
- wr_par  in  1  parity bit used when par_mode = 1.
- ovf_clr  in  1  clears ovf.
- full  out  1  FIFO holds DEPTH words.
- level  out  $clog2(DEPTH+1)  words in FIFO, excluding the word being sent.
- ovf  out  1  sticky: a write was dropped while full.
- busy  out  1  FSM not IDLE.
- word_done  out  1  one-cycle pulse at end of bit 32.
- txd1  out  1  line HI drive.
- txd0  out  1  line LO drive.
- slp  out  1  slow slope select: 1 when the latched speed is 12.5 kb/s.

## Operation
- Reset values: full=0, level=0, ovf=0, busy=0, word_done=0, txd1=0, txd0=0, slp=0.
- Half-bit count NHALF = FCLK/(2*rate). At 50 MHz this gives 25 / 250 / 500 / 2000. The counter is 11 bits wide.
- Word bit order on the line:
  - label bit 7 (MSB) first, down to label bit 0;
  - then wr_data[0] up to wr_data[22];
  - then the parity bit.
- Odd parity: parity = ~^{wr_label, wr_data}. par_mode is captured at write time and stored per entry, so the FIFO entry is 33 bits.
- Each bit has two halves:
  - first half (NHALF cycles): txd1=1 for a '1' or txd0=1 for a '0';
  - second half (NHALF cycles): both lines 0.
- txd1 and txd0 are never 1 together.
- FSM states:
  - IDLE: go to LOAD when level>0.
  - LOAD (1 cycle): pop FIFO into a 32-bit shift register; latch nvel into speed and slp; bit counter = 0.
  - SEND: 32 bits; after bit 32's null half, pulse word_done and go to GAP.
  - GAP: GAP_BITS*2*NHALF cycles with both lines 0. Then go to LOAD if level>0, else IDLE.
- nvel changes are ignored until the next LOAD. The speed is constant within a word and its following gap.
- FIFO boundary rules:
  - Write while not full: accepted.
  - Write while full and a pop in the same cycle: accepted (pop frees the slot).
  - Write while full and no pop: dropped, FIFO unchanged, ovf set.
  - ovf_clr clears ovf; if ovf_clr and an overflow occur in the same cycle, ovf stays 1.
- Reset mid-word: both lines go to 0 on the next cycle, the FIFO is emptied, and no word_done is issued.

## Timing
- Write in cycle n into an empty FIFO while IDLE:
  - level=1 at n+1;
  - LOAD at n+1 (level back to 0 at n+2);
  - first line half-bit starts at n+2.
- Word duration is 64*NHALF cycles. word_done is high in the last cycle of bit 32's null half.
- Back-to-back words: next word's first half-bit starts GAP_BITS*2*NHALF + 1 cycles after the word_done cycle (gap plus one LOAD cycle).
- full and level are registered and update the cycle after a write or pop.
- busy rises with LOAD and falls on the cycle IDLE is entered.

## Test plan
- nvel=2, par_mode=0, write label=0x81, data=0x000001: txd1 high 250 cycles starting at n+2. Line sequence 1,0,0,0,0,0,0,1, then 1, then twenty-two 0s, then parity 0 (three ones). word_done at n+2+16000-1.
- nvel=3, write 3 words back-to-back: each word spans 1600 cycles, gaps are 200 cycles, no extra idle between words. level steps 2,1,0.
- Fill DEPTH=8 words while the line is sending, then a 9th write: full=1, ovf=1, and the 9th word is never transmitted. ovf_clr → ovf=0.
- par_mode=1, wr_par=0 with an even number of ones: bit 32 is sent as 0 (even parity preserved). par_mode=0 on the same data gives bit 32 = 1.
- nvel=0 latched, then change nvel to 3 mid-word: the whole word keeps NHALF=2000 and slp=1. The next word uses NHALF=25 and slp=0.
- Assert reset at bit 10 with 3 words queued: txd1=txd0=0 the next cycle, level=0, busy=0, and no word_done.
